shift_add_mult_ctrl: RTL
========================

Name: shift_add_mult_ctrl

Overview:
FSM controller that sequences the shift-add multiplier datapath: the multiplicand left-shift register (load/en), the multiplier right-shift register, and the product accumulator. On a start pulse it loads both shift registers and clears the accumulator. It then runs up to n add/shift steps, with optional early termination once the multiplier is exhausted. It signals completion with a one-cycle done pulse and sits between the top-level operand/command interface and the datapath registers.

Parameters:
n, 8, operand width; sets the maximum number of RUN steps. CNT_W = clog2(n+1) is derived internally and is not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  begin a multiplication; sampled in IDLE and DONE only
early_exit_en  input  1  1 = terminate as soon as the multiplier register is zero
mplier_lsb  input  1  bit 0 of the multiplier right-shift register
mplier_zero  input  1  1 when the multiplier right-shift register is all zeros
load  output  1  load both shift registers with the operands
acc_clear  output  1  clear the product accumulator
acc_add_en  output  1  accumulator += shifted multiplicand this cycle
mcand_shift_en  output  1  shift enable, multiplicand left-shift register
mplier_shift_en  output  1  shift enable, multiplier right-shift register
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
step_count  output  CNT_W  shift steps performed in the current/last operation

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst=1 at a rising edge of clk forces the reset state.
- Reset state: IDLE, step_count=0, all outputs 0. rst has priority over every other input, including start.
- States: IDLE, LOAD, RUN, DONE. State and step_count are registered.
- All outputs are decoded combinationally from state. acc_add_en additionally depends on mplier_lsb.
- IDLE: all control outputs 0, step_count holds. start=1 -> LOAD.
- LOAD, always exactly one cycle:
  - load=1, acc_clear=1, busy=1, shift enables 0, acc_add_en=0.
  - step_count <= 0.
  - Next state -> RUN.
- RUN, busy=1. Evaluated every cycle in this order:
  - If early_exit_en=1 and mplier_zero=1: no add, no shift (acc_add_en=0, both shift enables 0), step_count holds, -> DONE.
  - Otherwise: acc_add_en=mplier_lsb, mcand_shift_en=1, mplier_shift_en=1, step_count <= step_count+1.
  - When step_count == n-1 at that edge (the n-th step), -> DONE; else stay in RUN.
- Maximum RUN length is n cycles. step_count never exceeds n, and no wrap-around is possible.
- Add and shift in the same cycle are intended: the datapath adds the pre-shift multiplicand while both registers shift at that edge.
- DONE, exactly one cycle:
  - done=1, busy=0, other controls 0, step_count holds.
  - start=1 -> LOAD (back-to-back operation); else -> IDLE.
- start in LOAD or RUN is ignored; there is no queuing.
- Latency, with start sampled at edge k:
  - LOAD occupies cycle k+1.
  - RUN occupies k+2 … k+n+1.
  - done is high in cycle k+n+2.
  - Early exit shortens RUN to (shifts performed + 1) cycles.
- mplier_zero is checked in every RUN cycle, including the first. Multiplier = 0 with early_exit_en=1 gives done in cycle k+3 and step_count=0.
- early_exit_en=0: exactly n RUN cycles regardless of operand values.
- Reset mid-operation: next edge returns to IDLE with all outputs 0 and step_count=0. The controller does not clear datapath contents; the next start re-loads them.
- done and busy are never high simultaneously. load and any shift enable are never high simultaneously.

Test Plan:
1. Reset then idle: hold rst 2 cycles with start=1 -> state IDLE, every output 0, step_count=0, no LOAD entered.
2. n=8, early_exit_en=0, mcand=0x37, mplier=0xA5, behavioural datapath model attached, start pulse at edge k -> load/acc_clear high cycle k+1; acc_add_en pattern 1,0,1,0,0,1,0,1 over cycles k+2..k+9; done cycle k+10; step_count=8; product 0x2373.
3. Early exit: early_exit_en=1, mcand=0x37, mplier=0x05 -> 3 shift cycles with acc_add_en 1,0,1, then one RUN cycle with no shift; done cycle k+6; step_count=3; product 0x0113.
4. Zero multiplier: early_exit_en=1, mplier=0x00 -> one RUN cycle, no add/shift; done cycle k+3; step_count=0; product 0. Repeat with early_exit_en=0 -> 8 RUN cycles, acc_add_en never high, done cycle k+10.
5. Handshake: start pulsed during RUN -> ignored, done still at k+10; start held high in DONE -> LOAD the next cycle, second operation 0xFF×0xFF completes with product 0xFE01.
6. Reset mid-RUN: rst asserted on the 4th RUN cycle -> IDLE next edge, outputs 0, step_count=0, no done pulse; a subsequent start with 0x37×0xA5 completes normally with 0x2373.

Source files
------------

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for a shift-add multiplier. It loads the operand shift registers,
// then runs up to n add/shift steps, optionally stopping early once the
// multiplier register is empty, and finishes with a one-cycle done pulse.
module shift_add_mult_ctrl #(
  parameter  int n     = 8,
  localparam int CNT_W = $clog2(n + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             early_exit_en,
  input  logic             mplier_lsb,
  input  logic             mplier_zero,
  output logic             load,
  output logic             acc_clear,
  output logic             acc_add_en,
  output logic             mcand_shift_en,
  output logic             mplier_shift_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(n - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_step_count;
  logic [CNT_W-1:0] w_next_count;
  logic             w_exit_now;

  // An empty multiplier only ends the run when early exit is enabled.
  assign w_exit_now = early_exit_en & mplier_zero;

  // State and step counter registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_step_count <= '0;
    end else begin
      r_state      <= w_next_state;
      r_step_count <= w_next_count;
    end
  end

  // Next-state and counter update, plus the control decode for each state.
  always_comb begin
    w_next_state    = r_state;
    w_next_count    = r_step_count;
    load            = 1'b0;
    acc_clear       = 1'b0;
    acc_add_en      = 1'b0;
    mcand_shift_en  = 1'b0;
    mplier_shift_en = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next_state = LOAD;
      end
      LOAD: begin
        load         = 1'b1;
        acc_clear    = 1'b1;
        busy         = 1'b1;
        w_next_count = '0;
        w_next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_exit_now) begin
          w_next_state = DONE;
        end else begin
          // Add uses the pre-shift multiplicand; both registers shift on the same edge.
          acc_add_en      = mplier_lsb;
          mcand_shift_en  = 1'b1;
          mplier_shift_en = 1'b1;
          w_next_count    = r_step_count + 1'b1;
          if (r_step_count == LAST_STEP) w_next_state = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = start ? LOAD : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign step_count = r_step_count;

endmodule
